conbus_rr: RTL

CONBUS_RR -- requirements
Module: conbus_rr

---
 rtl/conbus_rr_pkg.sv | 30 +++
 rtl/conbus_rr_arb.sv | 89 ++++++++
 rtl/conbus_rr.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/conbus_rr_pkg.sv
// ============================================================================
// Module   : conbus_rr_pkg
// Purpose  : Shared constants and types for the round-robin Wishbone
//            interconnect. Holds the bus field widths (data 32, CTI 3,
//            SEL 4) and the arbiter FSM state encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package conbus_rr_pkg;

   // Wishbone field widths shared by every port of the interconnect
   localparam int DAT_W = 32;
   localparam int CTI_W = 3;
   localparam int SEL_W = 4;

   // Arbiter FSM encodings: bus free, or locked to one master's cycle
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

   // Width of an index into n items (at least one bit so n=1 still works)
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/conbus_rr_arb.sv
// ============================================================================
// Module   : conbus_rr_arb
// Purpose  : Round-robin arbiter with bus locking. A grant is held for as
//            long as the granted master keeps its request (cyc) high, so
//            bursts are never split. When the owner releases, the next
//            requester after the last grant wins; with no requester the bus
//            returns to IDLE and the grant clears.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conbus_rr_arb
   import conbus_rr_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         sys_clk,
   input  logic         sys_rst_n,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);

   localparam int              IW       = idx_w(N);
   // After reset master 0 must be first in line, so "last" starts at N-1
   localparam logic [IW-1:0]   LAST_RST = IW'(N - 1);

   arb_state_e      state_q, state_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic [IW-1:0]   last_gnt_q, last_gnt_d;

   logic            found;
   logic [IW-1:0]   pick;
   logic [IW:0]     sum;
   logic            hold;

   // Find the first requester strictly after last_gnt, wrapping N-1 -> 0
   always_comb begin
      found = 1'b0;
      pick  = last_gnt_q;
      sum   = '0;
      for (int k = 1; k <= N; k++) begin
         sum = {1'b0, last_gnt_q} + (IW+1)'(k);
         if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
         end
         if (!found && req[sum[IW-1:0]]) begin
            found = 1'b1;
            pick  = sum[IW-1:0];
         end
      end
   end

   // Next state: hold while the owner keeps cyc, otherwise re-arbitrate
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_gnt_d = last_gnt_q;
      hold       = (state_q == ST_BUSY) && (|(gnt_q & req));
      if (!hold) begin
         if (found) begin
            state_d     = ST_BUSY;
            gnt_d       = '0;
            gnt_d[pick] = 1'b1;
            last_gnt_d  = pick;
         end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      end
   end

   // Arbiter state registers
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         last_gnt_q <= LAST_RST;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_gnt_q <= last_gnt_d;
      end
   end

   assign gnt = gnt_q;

endmodule

`default_nettype wire

// File: rtl/conbus_rr.sv
// ============================================================================
// Module   : conbus_rr
// Purpose  : N_MASTERS x N_SLAVES shared-bus Wishbone interconnect with a
//            round-robin, cycle-locking arbiter. The granted master's
//            signals drive the shared slave bus; the slave is decoded from
//            the top S_ADDR_W address bits. Unmapped accesses get a single
//            registered err pulse.
// Options  : define CONBUS_RR_TIMEOUT_EN to add a response watchdog that
//            raises err after TIMEOUT unanswered strobe cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conbus_rr
   import conbus_rr_pkg::*;
#(
   parameter int                            N_MASTERS = 4,
   parameter int                            N_SLAVES  = 7,
   parameter int                            S_ADDR_W  = 3,
   parameter logic [N_SLAVES*S_ADDR_W-1:0]  S_ADDRS   = {3'h6, 3'h5, 3'h4, 3'h3, 3'h2, 3'h1, 3'h0},
   parameter int                            TIMEOUT   = 255
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst_n,
   // master side
   input  logic [N_MASTERS*DAT_W-1:0]    m_adr_i,
   input  logic [N_MASTERS*DAT_W-1:0]    m_dat_i,
   input  logic [N_MASTERS*CTI_W-1:0]    m_cti_i,
   input  logic [N_MASTERS*SEL_W-1:0]    m_sel_i,
   input  logic [N_MASTERS-1:0]          m_we_i,
   input  logic [N_MASTERS-1:0]          m_cyc_i,
   input  logic [N_MASTERS-1:0]          m_stb_i,
   output logic [DAT_W-1:0]              m_dat_o,
   output logic [N_MASTERS-1:0]          m_ack_o,
   output logic [N_MASTERS-1:0]          m_err_o,
   // slave side
   output logic [DAT_W-1:0]              s_adr_o,
   output logic [DAT_W-1:0]              s_dat_o,
   output logic [CTI_W-1:0]              s_cti_o,
   output logic [SEL_W-1:0]              s_sel_o,
   output logic                          s_we_o,
   output logic [N_SLAVES-1:0]           s_cyc_o,
   output logic [N_SLAVES-1:0]           s_stb_o,
   input  logic [N_SLAVES*DAT_W-1:0]     s_dat_i,
   input  logic [N_SLAVES-1:0]           s_ack_i
);

   logic [N_MASTERS-1:0] gnt;
   logic                 cyc_g;
   logic                 stb_g;
   logic [N_SLAVES-1:0]  slv_sel;
   logic                 slv_hit;
   logic                 ack_sel;
   logic                 unmapped;
   logic                 tmo_hit;
   logic [N_MASTERS-1:0] err_q, err_d;

   conbus_rr_arb #(
      .N (N_MASTERS)
   ) u_arb (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .req       (m_cyc_i),
      .gnt       (gnt)
   );

   // AND-OR mux of the granted master onto the shared bus; all zero when idle
   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_cti_o = '0;
      s_sel_o = '0;
      s_we_o  = 1'b0;
      cyc_g   = 1'b0;
      stb_g   = 1'b0;
      for (int i = 0; i < N_MASTERS; i++) begin
         s_adr_o = s_adr_o | (m_adr_i[i*DAT_W +: DAT_W] & {DAT_W{gnt[i]}});
         s_dat_o = s_dat_o | (m_dat_i[i*DAT_W +: DAT_W] & {DAT_W{gnt[i]}});
         s_cti_o = s_cti_o | (m_cti_i[i*CTI_W +: CTI_W] & {CTI_W{gnt[i]}});
         s_sel_o = s_sel_o | (m_sel_i[i*SEL_W +: SEL_W] & {SEL_W{gnt[i]}});
         s_we_o  = s_we_o  | (m_we_i[i]  & gnt[i]);
         cyc_g   = cyc_g   | (m_cyc_i[i] & gnt[i]);
         stb_g   = stb_g   | (m_stb_i[i] & gnt[i]);
      end
   end

   // Address decode: one-hot slave select, lowest index wins on duplicate tags
   always_comb begin
      slv_sel = '0;
      slv_hit = 1'b0;
      for (int k = 0; k < N_SLAVES; k++) begin
         if (!slv_hit &&
             (s_adr_o[DAT_W-1 -: S_ADDR_W] == S_ADDRS[k*S_ADDR_W +: S_ADDR_W])) begin
            slv_sel[k] = 1'b1;
            slv_hit    = 1'b1;
         end
      end
   end

   assign s_cyc_o  = slv_sel & {N_SLAVES{cyc_g}};
   assign s_stb_o  = slv_sel & {N_SLAVES{stb_g}};
   assign unmapped = cyc_g & stb_g & ~slv_hit;

   // Combinational return path from the selected slave to the granted master
   always_comb begin
      m_dat_o = '0;
      ack_sel = 1'b0;
      for (int k = 0; k < N_SLAVES; k++) begin
         if (slv_sel[k]) begin
            m_dat_o = s_dat_i[k*DAT_W +: DAT_W];
            ack_sel = s_ack_i[k];
         end
      end
      m_ack_o = gnt & {N_MASTERS{ack_sel}};
      // A slave ack takes priority so ack and err never coincide
      m_err_o = err_q & ~m_ack_o;
   end

`ifdef CONBUS_RR_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

   // Watchdog: count unanswered strobe cycles; the TIMEOUT-th one raises err.
   // A grant change always follows a cycle with the owner's cyc low, which
   // already clears the count, so no separate grant-change detect is needed.
   always_comb begin
      tmo_cnt_d = '0;
      tmo_hit   = 1'b0;
      if (cyc_g && stb_g && !ack_sel && !(|m_err_o)) begin
         if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            tmo_hit = 1'b1;
         end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
         end
      end
   end

   // Watchdog counter register
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // Error source: unmapped strobe (one pulse, not re-armed the cycle after
   // a pulse) or watchdog expiry, routed to whoever holds the grant
   always_comb begin
      err_d = '0;
      if ((unmapped && !(|err_q)) || tmo_hit) begin
         err_d = gnt;
      end
   end

   // Error pulse register
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

endmodule

`default_nettype wire
